// File: rtl/xsw_pkt_arb.sv
// xsw_pkt_arb: packet-locking round-robin N:1 arbiter with stall watchdog (clk, rst; req_i/last_i/en_i in; gnt_o one-hot0, sel_o index, vld_o beat, lock_o, abort_o pulse out)
module xsw_pkt_arb #(
  parameter int N = 4,
  parameter int TO_CYC = 16,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  last_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] sel_o,
  output logic          vld_o,
  output logic          lock_o,
  output logic          abort_o
);
  localparam int WW = TO_CYC > 0 ? $clog2(TO_CYC + 1) : 1;
  typedef enum logic {IDLE, LOCK} st_t;
  st_t st;
  logic [IW-1:0] ptr, own, win, idx;
  logic [WW-1:0] wcnt;
  logic wd_hit;
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return (x == IW'(N - 1)) ? '0 : x + 1'b1;
  endfunction
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req_i[idx]) win = idx;
    end
  end
  assign lock_o = (st == LOCK);
  assign sel_o  = lock_o ? own : win;
  assign gnt_o  = (lock_o || |req_i) ? N'(1) << sel_o : '0;
  assign vld_o  = |(gnt_o & req_i) & en_i;
  assign wd_hit = (TO_CYC > 0) && lock_o && !req_i[own] && (wcnt == WW'(TO_CYC - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      ptr     <= '0;
      own     <= '0;
      wcnt    <= '0;
      abort_o <= 1'b0;
    end else begin
      abort_o <= wd_hit;
      if (st == IDLE) begin
        if (vld_o && last_i[win]) ptr <= inc(win);
        else if (vld_o) begin
          st   <= LOCK;
          own  <= win;
          wcnt <= '0;
        end
      end else if ((vld_o && last_i[own]) || wd_hit) begin
        st   <= IDLE;
        ptr  <= inc(own);
        wcnt <= '0;
      end else if (req_i[own]) wcnt <= '0;
      else if (wcnt < WW'(TO_CYC)) wcnt <= wcnt + 1'b1;
    end
  end
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt_o));
      assert (!vld_o || |(gnt_o & req_i));
      assert (!lock_o || gnt_o == (N'(1) << own));
    end
  end
`endif
endmodule

// File: tb/tb_xsw_pkt_arb.sv
// tb_xsw_pkt_arb: directed and randomized checks of xsw_pkt_arb against a behavioural model
module tb_xsw_pkt_arb;
  localparam int N = 4;
  localparam int TO = 16;
  logic clk = 0, rst;
  logic [N-1:0] req, last, gnt;
  logic en, vld, lock, abort;
  logic [1:0] sel;
  int checks = 0, errors = 0;
  bit m_lock, m_abort;
  int m_own, m_ptr, m_wc;
  always #5 clk = ~clk;
  xsw_pkt_arb #(.N(N), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req), .last_i(last), .en_i(en),
    .gnt_o(gnt), .sel_o(sel), .vld_o(vld), .lock_o(lock), .abort_o(abort)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    m_lock = 0; m_abort = 0; m_own = 0; m_ptr = 0; m_wc = 0;
  endtask
  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic e);
    int w;
    bit ev, nab;
    logic [N-1:0] eg;
    req = r; last = l; en = e;
    w = -1;
    if (m_lock) w = m_own;
    else for (int k = 0; k < N; k++) if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    eg = (w < 0) ? '0 : N'(1) << w;
    ev = e && w >= 0 && r[w];
    #3;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("sel", 32'(sel), (w < 0) ? m_ptr : w);
    chk("vld", 32'(vld), 32'(ev));
    chk("lock", 32'(lock), 32'(m_lock));
    chk("abort", 32'(abort), 32'(m_abort));
    nab = 0;
    if (!m_lock) begin
      if (ev) begin
        if (l[w]) m_ptr = (w + 1) % N;
        else begin m_lock = 1; m_own = w; m_wc = 0; end
      end
    end else if (ev && l[m_own]) begin
      m_lock = 0; m_ptr = (m_own + 1) % N; m_wc = 0;
    end else if (r[m_own]) m_wc = 0;
    else if (m_wc == TO - 1) begin
      m_lock = 0; m_ptr = (m_own + 1) % N; m_wc = 0; nab = 1;
    end else m_wc++;
    m_abort = nab;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; req = 0; last = 0; en = 0;
    @(posedge clk);
    #1;
    do_reset();
    cyc(4'b0000, 4'b0000, 0);
    cyc(4'b0001, 4'b0001, 1);
    cyc(4'b0000, 4'b0000, 0);
    do_reset();
    repeat (8) cyc(4'b1111, 4'b1111, 1);
    cyc(4'b0110, 4'b0000, 1);
    cyc(4'b0110, 4'b0000, 1);
    cyc(4'b0110, 4'b0010, 1);
    cyc(4'b0100, 4'b0100, 1);
    do_reset();
    cyc(4'b0100, 4'b0000, 1);
    repeat (40) cyc(4'b0100, 4'b0000, 0);
    cyc(4'b0100, 4'b0100, 1);
    do_reset();
    cyc(4'b1000, 4'b0000, 1);
    repeat (16) cyc(4'b0001, 4'b0000, 0);
    cyc(4'b0001, 4'b0001, 1);
    cyc(4'b0000, 4'b0000, 0);
    do_reset();
    cyc(4'b0010, 4'b0000, 1);
    cyc(4'b0010, 4'b0000, 1);
    req = 4'b0010;
    do_reset();
    cyc(4'b1010, 4'b0000, 0);
    cyc(4'b1010, 4'b1000, 1);
    for (int b = 0; b < 60; b++) begin
      int d;
      d = $urandom_range(0, 4);
      for (int c = 0; c < 40; c++) begin
        logic [N-1:0] r, l;
        for (int i = 0; i < N; i++) begin
          r[i] = ($urandom_range(0, 3) < d);
          l[i] = ($urandom_range(0, 2) == 0);
        end
        if ($urandom_range(0, 199) == 0) do_reset();
        cyc(r, l, $urandom_range(0, 3) != 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
